// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control sequencer:
// opcode values, the 5-bit binary state encoding, control-word bit positions
// and a small opcode classification helper.
package cpu_pkg;

    localparam int unsigned STATE_W = 5;
    localparam int unsigned OPC_W   = 4;

    // Opcodes (IR[7:4])
    localparam logic [OPC_W-1:0] OP_NOP = 4'd0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'd2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'd3;
    localparam logic [OPC_W-1:0] OP_STA = 4'd4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'd5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'd6;
    localparam logic [OPC_W-1:0] OP_OUT = 4'd7;
    localparam logic [OPC_W-1:0] OP_HLT = 4'd15;

    // Sequencer states. ADD and SUB get their own execute states so that
    // alu_sel stays a pure function of the state register.
    localparam logic [STATE_W-1:0] S_IDLE = 5'd0;
    localparam logic [STATE_W-1:0] S_F0   = 5'd1;
    localparam logic [STATE_W-1:0] S_F1   = 5'd2;
    localparam logic [STATE_W-1:0] S_F2   = 5'd3;
    localparam logic [STATE_W-1:0] S_DEC  = 5'd4;
    localparam logic [STATE_W-1:0] S_M0   = 5'd5;
    localparam logic [STATE_W-1:0] S_M1   = 5'd6;
    localparam logic [STATE_W-1:0] S_M2   = 5'd7;
    localparam logic [STATE_W-1:0] S_MB   = 5'd8;
    localparam logic [STATE_W-1:0] S_X0A  = 5'd9;
    localparam logic [STATE_W-1:0] S_X1A  = 5'd10;
    localparam logic [STATE_W-1:0] S_X0S  = 5'd11;
    localparam logic [STATE_W-1:0] S_X1S  = 5'd12;
    localparam logic [STATE_W-1:0] S_ST   = 5'd13;
    localparam logic [STATE_W-1:0] S_IM   = 5'd14;
    localparam logic [STATE_W-1:0] S_JP   = 5'd15;
    localparam logic [STATE_W-1:0] S_OT   = 5'd16;
    localparam logic [STATE_W-1:0] S_HALT = 5'd17;

    // Control-word bit positions
    localparam int unsigned CW_W          = 15;
    localparam int unsigned CW_MAR_LD_PC  = 0;
    localparam int unsigned CW_MAR_LD_IR  = 1;
    localparam int unsigned CW_RAM_RD     = 2;
    localparam int unsigned CW_RAM_WR     = 3;
    localparam int unsigned CW_PC_INC     = 4;
    localparam int unsigned CW_PC_LD      = 5;
    localparam int unsigned CW_IR_LD      = 6;
    localparam int unsigned CW_A_LD_MEM   = 7;
    localparam int unsigned CW_A_LD_ALU   = 8;
    localparam int unsigned CW_A_LD_IMM   = 9;
    localparam int unsigned CW_B_LD_MEM   = 10;
    localparam int unsigned CW_ALU_SEL    = 11;
    localparam int unsigned CW_OUT_LD     = 12;
    localparam int unsigned CW_HALTED     = 13;
    localparam int unsigned CW_INSTR_DONE = 14;

    // True for NOP and the undefined opcodes 8..14: the instruction ends in DEC.
    function automatic logic op_ends_at_dec(input logic [OPC_W-1:0] op);
        logic ends;
        ends = 1'b1;
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA,
            OP_LDI, OP_JMP, OP_OUT, OP_HLT: ends = 1'b0;
            default:                        ends = 1'b1;
        endcase
        return ends;
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Output decode for the control sequencer: state -> control word.
// Ports:
//   state  in  current sequencer state
//   ir_op  in  opcode from the IR (only used to flag NOP-class ends in DEC)
//   cw_c   out combinational control word, bit positions from cpu_pkg
module cpu_ctrl_decode
    import cpu_pkg::*;
#(
    parameter int unsigned OP_W = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic [OP_W-1:0]    ir_op,
    output logic [CW_W-1:0]    cw_c
);

    // One strobe group per state; anything unlisted decodes to all-zero.
    always_comb begin
        cw_c = '0;
        case (state)
            S_F0: cw_c[CW_MAR_LD_PC] = 1'b1;
            S_F1: begin
                cw_c[CW_RAM_RD]  = 1'b1;
                cw_c[CW_PC_INC]  = 1'b1;
            end
            S_F2: cw_c[CW_IR_LD] = 1'b1;
            // DEC is the last state only for NOP-class opcodes; the IR is
            // stable here, so this term is glitch-free in practice.
            S_DEC: cw_c[CW_INSTR_DONE] = op_ends_at_dec(OPC_W'(ir_op));
            S_M0: cw_c[CW_MAR_LD_IR] = 1'b1;
            S_M1: cw_c[CW_RAM_RD]    = 1'b1;
            S_M2: begin
                cw_c[CW_A_LD_MEM]   = 1'b1;
                cw_c[CW_INSTR_DONE] = 1'b1;
            end
            S_MB:  cw_c[CW_B_LD_MEM] = 1'b1;
            S_X0A: cw_c              = '0;
            S_X1A: begin
                cw_c[CW_A_LD_ALU]   = 1'b1;
                cw_c[CW_INSTR_DONE] = 1'b1;
            end
            S_X0S: cw_c[CW_ALU_SEL]  = 1'b1;
            S_X1S: begin
                cw_c[CW_ALU_SEL]    = 1'b1;
                cw_c[CW_A_LD_ALU]   = 1'b1;
                cw_c[CW_INSTR_DONE] = 1'b1;
            end
            S_ST: begin
                cw_c[CW_RAM_WR]     = 1'b1;
                cw_c[CW_INSTR_DONE] = 1'b1;
            end
            S_IM: begin
                cw_c[CW_A_LD_IMM]   = 1'b1;
                cw_c[CW_INSTR_DONE] = 1'b1;
            end
            S_JP: begin
                cw_c[CW_PC_LD]      = 1'b1;
                cw_c[CW_INSTR_DONE] = 1'b1;
            end
            S_OT: begin
                cw_c[CW_OUT_LD]     = 1'b1;
                cw_c[CW_INSTR_DONE] = 1'b1;
            end
            S_HALT:  cw_c[CW_HALTED] = 1'b1;
            default: cw_c = '0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Microsequencer for the 8-bit accumulator CPU: fetch, decode, execute.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (forces IDLE)
//   run             execute enable, sampled in IDLE and at each instruction end
//   ir_op           opcode from the IR, valid from DEC onward
//   mar_ld_pc/ir    MAR load strobes
//   ram_rd/ram_wr   RAM read / write strobes
//   pc_inc/pc_ld    PC increment / load
//   ir_ld           IR load from RAM data
//   a_ld_mem/alu/imm, b_ld_mem, out_ld   register load strobes
//   alu_sel         0 = add, 1 = subtract
//   halted          high while in HALT
//   instr_done      pulse on the last state of each instruction
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int unsigned OP_W        = 4,
    parameter bit          HALT_STICKY = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [OP_W-1:0] ir_op,
    output logic            mar_ld_pc,
    output logic            mar_ld_ir,
    output logic            ram_rd,
    output logic            ram_wr,
    output logic            pc_inc,
    output logic            pc_ld,
    output logic            ir_ld,
    output logic            a_ld_mem,
    output logic            a_ld_alu,
    output logic            a_ld_imm,
    output logic            b_ld_mem,
    output logic            alu_sel,
    output logic            out_ld,
    output logic            halted,
    output logic            instr_done
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [OPC_W-1:0]   op;
    logic [STATE_W-1:0] end_state;
    logic [CW_W-1:0]    cw_c;

    assign op = OPC_W'(ir_op);

    // Where every instruction goes after its last state.
    assign end_state = run ? S_F0 : S_IDLE;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE: next_state = run ? S_F0 : S_IDLE;
            S_F0:   next_state = S_F1;
            S_F1:   next_state = S_F2;
            S_F2:   next_state = S_DEC;
            S_DEC: begin
                case (op)
                    OP_LDA, OP_ADD,
                    OP_SUB, OP_STA: next_state = S_M0;
                    OP_LDI:         next_state = S_IM;
                    OP_JMP:         next_state = S_JP;
                    OP_OUT:         next_state = S_OT;
                    OP_HLT:         next_state = S_HALT;
                    default:        next_state = end_state;
                endcase
            end
            S_M0:  next_state = (op == OP_STA) ? S_ST : S_M1;
            S_M1:  next_state = (op == OP_LDA) ? S_M2 : S_MB;
            S_MB:  next_state = (op == OP_SUB) ? S_X0S : S_X0A;
            // X0 lets the ALU register its operands before A takes the result.
            S_X0A: next_state = S_X1A;
            S_X0S: next_state = S_X1S;
            S_M2, S_X1A, S_X1S, S_ST,
            S_IM, S_JP, S_OT: next_state = end_state;
            S_HALT: begin
                if (HALT_STICKY) begin
                    next_state = S_HALT;
                end else begin
                    next_state = run ? S_HALT : S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    cpu_ctrl_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .state (state),
        .ir_op (ir_op),
        .cw_c  (cw_c)
    );

    assign mar_ld_pc  = cw_c[CW_MAR_LD_PC];
    assign mar_ld_ir  = cw_c[CW_MAR_LD_IR];
    assign ram_rd     = cw_c[CW_RAM_RD];
    assign ram_wr     = cw_c[CW_RAM_WR];
    assign pc_inc     = cw_c[CW_PC_INC];
    assign pc_ld      = cw_c[CW_PC_LD];
    assign ir_ld      = cw_c[CW_IR_LD];
    assign a_ld_mem   = cw_c[CW_A_LD_MEM];
    assign a_ld_alu   = cw_c[CW_A_LD_ALU];
    assign a_ld_imm   = cw_c[CW_A_LD_IMM];
    assign b_ld_mem   = cw_c[CW_B_LD_MEM];
    assign alu_sel    = cw_c[CW_ALU_SEL];
    assign out_ld     = cw_c[CW_OUT_LD];
    assign halted     = cw_c[CW_HALTED];
    assign instr_done = cw_c[CW_INSTR_DONE];

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench for cpu_ctrl_seq: the stimulus process pushes the expected
// strobe word for each cycle; the monitor pops and compares at the falling edge.
module tb_cpu_ctrl_seq;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] ir_op;
    logic mar_ld_pc, mar_ld_ir, ram_rd, ram_wr, pc_inc, pc_ld, ir_ld;
    logic a_ld_mem, a_ld_alu, a_ld_imm, b_ld_mem, alu_sel, out_ld, halted, instr_done;

    // Expected-word bit masks, in the order of the act concatenation below.
    localparam logic [14:0] MPC   = 15'h4000;
    localparam logic [14:0] MIR   = 15'h2000;
    localparam logic [14:0] RD    = 15'h1000;
    localparam logic [14:0] WR    = 15'h0800;
    localparam logic [14:0] INC   = 15'h0400;
    localparam logic [14:0] PCLD  = 15'h0200;
    localparam logic [14:0] IRLD  = 15'h0100;
    localparam logic [14:0] AMEM  = 15'h0080;
    localparam logic [14:0] AALU  = 15'h0040;
    localparam logic [14:0] AIMM  = 15'h0020;
    localparam logic [14:0] BMEM  = 15'h0010;
    localparam logic [14:0] SEL   = 15'h0008;
    localparam logic [14:0] OUTLD = 15'h0004;
    localparam logic [14:0] HLTD  = 15'h0002;
    localparam logic [14:0] DONE  = 15'h0001;
    localparam logic [14:0] NONE  = 15'h0000;

    logic [14:0] act;
    assign act = {mar_ld_pc, mar_ld_ir, ram_rd, ram_wr, pc_inc, pc_ld, ir_ld,
                  a_ld_mem, a_ld_alu, a_ld_imm, b_ld_mem, alu_sel, out_ld,
                  halted, instr_done};

    logic [14:0] exp_w[$];
    string       exp_n[$];
    int          vectors = 0;
    int          miscompares = 0;

    cpu_ctrl_seq dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ir_op      (ir_op),
        .mar_ld_pc  (mar_ld_pc),
        .mar_ld_ir  (mar_ld_ir),
        .ram_rd     (ram_rd),
        .ram_wr     (ram_wr),
        .pc_inc     (pc_inc),
        .pc_ld      (pc_ld),
        .ir_ld      (ir_ld),
        .a_ld_mem   (a_ld_mem),
        .a_ld_alu   (a_ld_alu),
        .a_ld_imm   (a_ld_imm),
        .b_ld_mem   (b_ld_mem),
        .alu_sel    (alu_sel),
        .out_ld     (out_ld),
        .halted     (halted),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected word per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_w.size() > 0) begin
            logic [14:0] w;
            string       n;
            w = exp_w.pop_front();
            n = exp_n.pop_front();
            vectors++;
            if (act !== w) begin
                miscompares++;
                $display("FAIL %s: got %b, expected %b", n, act, w);
            end
        end
    end

    // Queue the expected word for the current cycle, then advance one clock.
    task automatic step(input logic [14:0] w, input string name);
        exp_w.push_back(w);
        exp_n.push_back(name);
        @(posedge clk);
        #1;
    endtask

    // Hand-written strobe sequence of one instruction from F0 to its last
    // state. drop_at: cycle index where run falls; rst_at: cycle index where
    // rst is raised (sequence abandoned there). -1 disables either.
    task automatic run_instr(input logic [3:0] op, input string tag,
                             input int drop_at, input int rst_at);
        logic [14:0] q[$];
        q = {MPC, RD | INC, IRLD};
        case (op)
            4'd1:  q = {q, NONE, MIR, RD, AMEM | DONE};
            4'd2:  q = {q, NONE, MIR, RD, BMEM, NONE, AALU | DONE};
            4'd3:  q = {q, NONE, MIR, RD, BMEM, SEL, AALU | SEL | DONE};
            4'd4:  q = {q, NONE, MIR, WR | DONE};
            4'd5:  q = {q, NONE, AIMM | DONE};
            4'd6:  q = {q, NONE, PCLD | DONE};
            4'd7:  q = {q, NONE, OUTLD | DONE};
            4'd15: q = {q, NONE};
            default: q = {q, DONE};
        endcase
        ir_op = op;
        for (int i = 0; i < q.size(); i++) begin
            if (i == drop_at) run = 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                step(NONE, $sformatf("%s_rst[%0d]", tag, i));
                return;
            end
            step(q[i], $sformatf("%s[%0d]", tag, i));
        end
    endtask

    initial begin
        rst   = 1'b1;
        run   = 1'b0;
        ir_op = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        step(NONE, "in_reset");
        rst = 1'b0;
        repeat (3) step(NONE, "idle_run0");

        run = 1'b1;
        step(NONE, "idle_to_f0");
        run_instr(4'd5,  "ldi",   -1, -1);
        run_instr(4'd7,  "out",   -1, -1);
        run_instr(4'd2,  "add",   -1, -1);
        run_instr(4'd3,  "sub",   -1, -1);
        run_instr(4'd4,  "sta",   -1, -1);
        run_instr(4'd6,  "jmp",   -1, -1);
        run_instr(4'd0,  "nop",   -1, -1);
        run_instr(4'd9,  "undef", -1, -1);

        // run falls in M1 of LDA: the load still completes, then IDLE.
        run_instr(4'd1, "lda_drop", 5, -1);
        step(NONE, "idle_after_drop");
        run = 1'b1;
        step(NONE, "idle_rerun");
        run_instr(4'd0, "nop_after_drop", -1, -1);

        // Reset in X0 of ADD discards the instruction.
        run_instr(4'd2, "add_x0", -1, 7);
        run = 1'b0;
        step(NONE, "rst_hold");
        rst = 1'b0;
        repeat (10) step(NONE, "idle10");

        // HLT: sticky halt, run toggling must not release it.
        run = 1'b1;
        step(NONE, "idle_to_hlt");
        run_instr(4'd15, "hlt", -1, -1);
        for (int i = 0; i < 20; i++) begin
            run = !(i >= 8 && i < 12);
            step(HLTD, $sformatf("halt[%0d]", i));
        end
        rst = 1'b1;
        step(NONE, "halt_rst");
        rst = 1'b0;
        run = 1'b0;
        repeat (2) step(NONE, "idle_after_halt");

        for (int i = 0; i < 10 && exp_w.size() > 0; i++) @(posedge clk);
        if (exp_w.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", exp_w.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
